// File: rtl/core_ibex_dbg_stim_ctrl_pkg.sv
// rtl/core_ibex_dbg_stim_ctrl_pkg.sv - shared types for the debug/fetch stimulus engine
package core_ibex_dbg_stim_ctrl_pkg;

    typedef enum logic [1:0] {
        DBG_PULSE      = 2'd0,
        DBG_UNTIL_DRET = 2'd1,
        FETCH_OFF      = 2'd2,
        FETCH_ON       = 2'd3
    } dbg_stim_op_e;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PULSE     = 2'd1,
        WAIT_DRET = 2'd2
    } dbg_stim_state_e;

    // Plain-vector FSM encoding kept for legacy consumers of the state bits.
    localparam logic [1:0] StIdle     = 2'd0;
    localparam logic [1:0] StPulse    = 2'd1;
    localparam logic [1:0] StWaitDret = 2'd2;

endpackage

// File: rtl/core_ibex_dbg_stim_ctrl_if.sv
// rtl/core_ibex_dbg_stim_ctrl_if.sv - command, core-pin and status bundle of the stimulus engine
interface core_ibex_dbg_stim_ctrl_if
    import core_ibex_dbg_stim_ctrl_pkg::*;
#(
    parameter int CntW  = 16,
    parameter int StatW = 8
);
    logic              cmd_valid;
    logic              cmd_ready;
    dbg_stim_op_e      cmd_op;
    logic [CntW-1:0]   cmd_len;
    logic              abort;
    logic              dret;
    logic              core_sleep;
    logic              debug_req;
    logic              fetch_enable;
    logic              done;
    logic              timeout;
    logic              busy;
    logic [StatW-1:0]  dret_cnt;

    modport master (
        output cmd_valid, cmd_op, cmd_len, abort, dret, core_sleep,
        input  cmd_ready, debug_req, fetch_enable, done, timeout, busy, dret_cnt
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_len, abort, dret, core_sleep,
        output cmd_ready, debug_req, fetch_enable, done, timeout, busy, dret_cnt
    );
endinterface

// File: rtl/core_ibex_dbg_stim_ctrl.sv
// rtl/core_ibex_dbg_stim_ctrl.sv - cycle-exact debug request / fetch enable sequencer
module core_ibex_dbg_stim_ctrl
    import core_ibex_dbg_stim_ctrl_pkg::*;
#(
    parameter int   CntW         = 16,
    parameter int   StatW        = 8,
    parameter logic FetchOnReset = 1'b1
) (
    input logic                    clk,
    input logic                    rst_n,
    core_ibex_dbg_stim_ctrl_if.slave bus
);

    logic [1:0]       state_q;
    logic [CntW-1:0]  cnt_q;
    logic             cmd_ready_q;
    logic             debug_req_q;
    logic             fetch_enable_q;
    logic             done_q;
    logic             timeout_q;
    logic             busy_q;
    logic [StatW-1:0] dret_cnt_q;

    logic accept;
    assign accept = bus.cmd_valid && cmd_ready_q && (state_q == StIdle);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= StIdle;
            cnt_q          <= '0;
            cmd_ready_q    <= 1'b0;
            debug_req_q    <= 1'b0;
            fetch_enable_q <= FetchOnReset;
            done_q         <= 1'b0;
            timeout_q      <= 1'b0;
            busy_q         <= 1'b0;
            dret_cnt_q     <= '0;
        end else begin
            done_q    <= 1'b0;
            timeout_q <= 1'b0;

            if (bus.dret && (dret_cnt_q != {StatW{1'b1}})) begin
                dret_cnt_q <= dret_cnt_q + 1'b1;
            end

            unique case (state_q)
                StPulse: begin
                    if (bus.abort || (cnt_q == '0)) begin
                        state_q     <= StIdle;
                        debug_req_q <= 1'b0;
                        done_q      <= 1'b1;
                        busy_q      <= 1'b0;
                        cmd_ready_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                StWaitDret: begin
                    // Abort and dret both beat a same-cycle timeout; a zero
                    // length parks cnt at 0 and never reaches the timeout test.
                    if (bus.abort || bus.dret || (cnt_q == CntW'(1))) begin
                        state_q     <= StIdle;
                        debug_req_q <= 1'b0;
                        done_q      <= 1'b1;
                        timeout_q   <= !bus.abort && !bus.dret;
                        busy_q      <= 1'b0;
                        cmd_ready_q <= 1'b1;
                    end else if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: begin
                    state_q     <= StIdle;
                    cmd_ready_q <= 1'b1;
                    if (accept) begin
                        unique case (bus.cmd_op)
                            DBG_PULSE: begin
                                state_q     <= StPulse;
                                debug_req_q <= 1'b1;
                                busy_q      <= 1'b1;
                                cmd_ready_q <= 1'b0;
                                cnt_q       <= (bus.cmd_len == '0) ? '0 : bus.cmd_len - 1'b1;
                            end
                            DBG_UNTIL_DRET: begin
                                state_q     <= StWaitDret;
                                debug_req_q <= 1'b1;
                                busy_q      <= 1'b1;
                                cmd_ready_q <= 1'b0;
                                cnt_q       <= bus.cmd_len;
                            end
                            FETCH_OFF: begin
                                fetch_enable_q <= 1'b0;
                                done_q         <= 1'b1;
                            end
                            FETCH_ON: begin
                                fetch_enable_q <= 1'b1;
                                done_q         <= 1'b1;
                            end
                        endcase
                    end
                end
            endcase
        end
    end

    assign bus.cmd_ready    = cmd_ready_q;
    assign bus.debug_req    = debug_req_q;
    assign bus.fetch_enable = fetch_enable_q;
    assign bus.done         = done_q;
    assign bus.timeout      = timeout_q;
    assign bus.busy         = busy_q;
    assign bus.dret_cnt     = dret_cnt_q;

endmodule

// File: tb/tb_core_ibex_dbg_stim_ctrl.sv
// tb/tb_core_ibex_dbg_stim_ctrl.sv - randomized bench with an event-level reference model
module tb_core_ibex_dbg_stim_ctrl;
    import core_ibex_dbg_stim_ctrl_pkg::*;

    localparam int   CntW         = 16;
    localparam int   StatW        = 8;
    localparam logic FetchOnReset = 1'b1;
    localparam int   DretMax      = (1 << StatW) - 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    core_ibex_dbg_stim_ctrl_if #(.CntW(CntW), .StatW(StatW)) bus ();

    core_ibex_dbg_stim_ctrl #(
        .CntW(CntW), .StatW(StatW), .FetchOnReset(FetchOnReset)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int   errors = 0;
    int   checks = 0;
    int   m_dret = 0;
    logic m_fetch = FetchOnReset;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic bump_dret();
        if (m_dret < DretMax) m_dret++;
    endtask

    // Expected completion edge n is the earliest of: natural end, dret, abort.
    task automatic run_cmd(input dbg_stim_op_e op, input int len, input int dret_at,
                           input int abort_at, input logic abort_on_accept);
        int n;
        bit to;
        n  = 0;
        to = 1'b0;
        if (op == DBG_PULSE) begin
            n = (len == 0) ? 1 : len;
        end else if (op == DBG_UNTIL_DRET) begin
            n  = (len == 0) ? 32'h4000_0000 : len;
            to = (len != 0);
            if (dret_at != 0 && dret_at <= n) begin
                n  = dret_at;
                to = 1'b0;
            end
        end
        if (n != 0 && abort_at != 0 && abort_at <= n) begin
            n  = abort_at;
            to = 1'b0;
        end

        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_len   = CntW'(len);
        bus.abort     = abort_on_accept;
        step();
        bus.cmd_valid = 1'b0;
        bus.abort     = 1'b0;
        bus.cmd_len   = CntW'($urandom);
        if (op == FETCH_OFF) m_fetch = 1'b0;
        if (op == FETCH_ON)  m_fetch = 1'b1;

        for (int k = 0; k <= n; k++) begin
            check_val("debug_req", 32'(bus.debug_req), 32'(k < n));
            check_val("done", 32'(bus.done), 32'(k == n));
            check_val("timeout", 32'(bus.timeout), 32'(k == n && to));
            check_val("busy", 32'(bus.busy), 32'(k < n));
            check_val("cmd_ready", 32'(bus.cmd_ready), 32'(k == n));
            check_val("fetch_enable", 32'(bus.fetch_enable), 32'(m_fetch));
            check_val("dret_cnt", 32'(bus.dret_cnt), 32'(m_dret));
            if (k < n) begin
                bus.dret       = (k + 1 == dret_at);
                bus.abort      = (k + 1 == abort_at);
                bus.core_sleep = 1'($urandom);
                step();
                if (bus.dret) bump_dret();
                bus.dret  = 1'b0;
                bus.abort = 1'b0;
            end
        end
        step();
        check_val("done_cleared", 32'(bus.done), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.cmd_valid  = 1'b0;
        bus.cmd_op     = DBG_PULSE;
        bus.cmd_len    = '0;
        bus.abort      = 1'b0;
        bus.dret       = 1'b0;
        bus.core_sleep = 1'b0;

        #12;
        check_val("rst_debug_req", 32'(bus.debug_req), 32'd0);
        check_val("rst_fetch", 32'(bus.fetch_enable), 32'(FetchOnReset));
        check_val("rst_ready", 32'(bus.cmd_ready), 32'd0);
        check_val("rst_dret_cnt", 32'(bus.dret_cnt), 32'd0);
        check_val("rst_busy", 32'(bus.busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        step();
        check_val("post_rst_ready", 32'(bus.cmd_ready), 32'd1);

        run_cmd(DBG_PULSE, 5, 0, 0, 1'b0);
        run_cmd(DBG_PULSE, 0, 0, 0, 1'b0);
        run_cmd(DBG_UNTIL_DRET, 100, 20, 0, 1'b0);
        run_cmd(DBG_UNTIL_DRET, 10, 0, 0, 1'b0);
        run_cmd(DBG_UNTIL_DRET, 10, 10, 0, 1'b0);
        run_cmd(DBG_UNTIL_DRET, 1, 0, 0, 1'b0);
        run_cmd(DBG_PULSE, 8, 0, 3, 1'b1);
        run_cmd(DBG_UNTIL_DRET, 0, 0, 7, 1'b0);

        // FETCH_OFF then FETCH_ON on consecutive edges
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = FETCH_OFF;
        step();
        check_val("foff_fetch", 32'(bus.fetch_enable), 32'd0);
        check_val("foff_done", 32'(bus.done), 32'd1);
        check_val("foff_ready", 32'(bus.cmd_ready), 32'd1);
        bus.cmd_op = FETCH_ON;
        step();
        bus.cmd_valid = 1'b0;
        m_fetch = 1'b1;
        check_val("fon_fetch", 32'(bus.fetch_enable), 32'd1);
        check_val("fon_done", 32'(bus.done), 32'd1);
        check_val("fon_ready", 32'(bus.cmd_ready), 32'd1);
        step();
        check_val("fon_done_cleared", 32'(bus.done), 32'd0);

        for (int i = 0; i < 40; i++) begin
            dbg_stim_op_e op;
            int len, dret_at, abort_at;
            op       = dbg_stim_op_e'($urandom_range(3, 0));
            len      = $urandom_range(12, 0);
            dret_at  = ($urandom_range(2, 0) == 0) ? 0 : $urandom_range(15, 1);
            abort_at = ($urandom_range(3, 0) == 0) ? $urandom_range(15, 1) : 0;
            if (op == DBG_UNTIL_DRET && len == 0 && dret_at == 0 && abort_at == 0) dret_at = 5;
            run_cmd(op, len, dret_at, abort_at, 1'($urandom));
        end

        for (int i = 0; i < 300; i++) begin
            bus.dret = 1'b1;
            step();
            bump_dret();
            bus.dret = 1'b0;
        end
        check_val("dret_cnt_sat", 32'(bus.dret_cnt), 32'(DretMax));
        check_val("dret_cnt_model", 32'(m_dret), 32'd255);

        // Asynchronous reset in the middle of an open-ended wait
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = DBG_UNTIL_DRET;
        bus.cmd_len   = '0;
        step();
        bus.cmd_valid = 1'b0;
        step();
        step();
        check_val("wait_debug_req", 32'(bus.debug_req), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("arst_debug_req", 32'(bus.debug_req), 32'd0);
        check_val("arst_busy", 32'(bus.busy), 32'd0);
        check_val("arst_done", 32'(bus.done), 32'd0);
        check_val("arst_dret_cnt", 32'(bus.dret_cnt), 32'd0);
        check_val("arst_fetch", 32'(bus.fetch_enable), 32'(FetchOnReset));
        step();
        check_val("arst_done_hold", 32'(bus.done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        m_dret  = 0;
        m_fetch = FetchOnReset;
        step();
        check_val("rerst_ready", 32'(bus.cmd_ready), 32'd1);
        check_val("rerst_done", 32'(bus.done), 32'd0);
        run_cmd(DBG_PULSE, 3, 2, 0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/core_ibex_dbg_stim_ctrl.md
Name: core_ibex_dbg_stim_ctrl

Overview:
- Drive-side counterpart to the core probe: sequences the core's debug request and fetch enable from a command stream, and watches the core's debug return and sleep responses.
- Sits in the core_ibex testbench between the debug/fetch sequences and the DUT inputs.
- Replaces ad-hoc pin wiggling with a handshaked, cycle-exact stimulus engine that reports completion, timeout and counts.

Parameters:
- CntW, 16, width of the command length/timeout field and internal counter.
- StatW, 8, width of the saturating debug-return event counter.
- FetchOnReset, 1'b1, value of fetch_enable_o during and after reset.

Ports:
- clk_i  input  1  clock.
- rst_ni  input  1  asynchronous active-low reset.
- cmd_valid_i  input  1  command valid.
- cmd_ready_o  output  1  command accepted when valid&&ready.
- cmd_op_i  input  2  command: 0 DBG_PULSE, 1 DBG_UNTIL_DRET, 2 FETCH_OFF, 3 FETCH_ON.
- cmd_len_i  input  CntW  pulse length, or timeout for DBG_UNTIL_DRET.
- abort_i  input  1  synchronous abort of the current command.
- dret_i  input  1  core executed dret (single-cycle pulse).
- core_sleep_i  input  1  core sleeping.
- debug_req_o  output  1  debug request to core.
- fetch_enable_o  output  1  fetch enable to core.
- done_o  output  1  one-cycle pulse when a command completes (including timeout/abort).
- timeout_o  output  1  one-cycle pulse, coincident with done_o, on DBG_UNTIL_DRET timeout.
- busy_o  output  1  FSM not in IDLE.
- dret_cnt_o  output  StatW  saturating count of dret_i pulses since reset.

Behaviour:
- Reset values: debug_req_o=0, fetch_enable_o=FetchOnReset, cmd_ready_o=0 in reset then 1, done_o=0, timeout_o=0, busy_o=0, dret_cnt_o=0, FSM=IDLE.
- All outputs are registered.
- cmd_ready_o = (state==IDLE). Commands are accepted only in IDLE; no queueing.
- IDLE, accept DBG_PULSE: next cycle debug_req_o=1, cnt=max(cmd_len_i,1)-1, go to PULSE.
- PULSE: while cnt!=0, decrement. At cnt==0, the next cycle drops debug_req_o, pulses done_o and returns to IDLE. debug_req_o is high for exactly max(len,1) cycles.
- IDLE, accept DBG_UNTIL_DRET: next cycle debug_req_o=1, cnt=cmd_len_i, go to WAIT_DRET.
- WAIT_DRET, dret_i=1: debug_req_o->0, done_o pulse, go to IDLE (1-cycle response).
- WAIT_DRET, cnt reaches 1 with no dret: debug_req_o->0, done_o+timeout_o pulse, go to IDLE.
- WAIT_DRET, len 0: no timeout; waits indefinitely.
- WAIT_DRET, dret_i and timeout in the same cycle: dret wins, timeout_o=0.
- FETCH_OFF / FETCH_ON: fetch_enable_o updates the cycle after acceptance, done_o pulses that same cycle, and the FSM stays IDLE (ready stays 1). cmd_len_i is ignored.
- abort_i in PULSE or WAIT_DRET: next cycle debug_req_o=0, done_o=1, timeout_o=0, go to IDLE.
- abort_i in IDLE: ignored, and a simultaneous command is still accepted.
- dret_cnt_o increments on every dret_i regardless of state and saturates at all-ones.
- core_sleep_i while debug_req_o=1: no effect on the FSM; the request stays asserted (core must wake on debug).
- Asynchronous reset mid-command: all state returns to reset values immediately, and no done_o is produced.
- busy_o = state inside {PULSE, WAIT_DRET}.

Decomposition:
- Shared tb package (core_ibex_env_pkg):
  - dbg_stim_op_e enum {DBG_PULSE, DBG_UNTIL_DRET, FETCH_OFF, FETCH_ON}
  - dbg_stim_state_e {IDLE, PULSE, WAIT_DRET}
- Single module, no sub-modules. The saturating counter is inline.

Test Plan:
- Reset with FetchOnReset=1 -> fetch_enable_o=1, debug_req_o=0, cmd_ready_o=1 after rst_ni rises, dret_cnt_o=0.
- DBG_PULSE len=5 -> debug_req_o high exactly 5 cycles starting 1 cycle after accept; done_o on the falling cycle; cmd_ready_o low meanwhile. Also len=0 -> 1 cycle.
- DBG_UNTIL_DRET len=100, dret_i at cycle 20 -> debug_req_o drops the cycle after dret; done_o=1, timeout_o=0; dret_cnt_o=1.
- DBG_UNTIL_DRET len=10, no dret -> debug_req_o high 10 cycles, then done_o=timeout_o=1; repeat with dret on the final cycle -> timeout_o=0.
- FETCH_OFF then FETCH_ON back-to-back -> fetch_enable_o 0 for exactly 1 cycle, two done_o pulses, cmd_ready_o stays 1.
- Mixed cases:
  - abort_i mid-PULSE -> debug_req_o=0, done_o next cycle.
  - 300 dret_i pulses with StatW=8 -> dret_cnt_o saturates at 255.
  - rst_ni low mid-WAIT_DRET -> debug_req_o=0 asynchronously, no done_o.
